boot_loader: RTL and testbench

//  Hardware replacement for the bench's $readmemh preload. Receives a framed byte stream,

---
 rtl/boot_loader_pkg.sv | 25 ++
 rtl/loader_word_assembler.sv | 39 +++
 rtl/boot_loader.sv | 152 +++++++++++++++
 tb/tb_boot_loader.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the boot loader: FSM states and frame/byte geometry.
package boot_loader_pkg;

  localparam int BYTE_W     = 8;
  localparam int WORD_BYTES = 2;
  localparam int LEN_BYTES  = 2;
  localparam int CSUM_BYTES = 1;
  localparam int WORD_W     = WORD_BYTES * BYTE_W;
  localparam int LEN_W      = LEN_BYTES * BYTE_W;
  localparam int CSUM_W     = CSUM_BYTES * BYTE_W;

  typedef enum logic [3:0] {
    S_Idle,
    S_LenHi,
    S_LenLo,
    S_DataHi,
    S_DataLo,
    S_Write,
    S_Check,
    S_Run,
    S_Halted,
    S_Error
  } state_t;

endpackage

// File: rtl/loader_word_assembler.sv
// Byte-to-word assembly (high byte first) plus running XOR checksum; registers update on the
// enabling cycle's edge, no backpressure of its own (the FSM gates every enable with a transfer).
module loader_word_assembler
  import boot_loader_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic [BYTE_W-1:0] byte_dat,
  input  logic              hi_en,
  input  logic              lo_en,
  input  logic              csum_clr,
  input  logic              csum_en,
  output logic [BYTE_W-1:0] hi_dat,
  output logic [WORD_W-1:0] word_dat,
  output logic [CSUM_W-1:0] csum
);

  logic [BYTE_W-1:0] hi_q;
  logic [BYTE_W-1:0] lo_q;
  logic [CSUM_W-1:0] csum_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      csum_q <= '0;
    end else begin
      if (hi_en) hi_q <= byte_dat;
      if (lo_en) lo_q <= byte_dat;
      if (csum_clr)     csum_q <= '0;
      else if (csum_en) csum_q <= csum_q ^ byte_dat;
    end
  end

  assign hi_dat   = hi_q;
  assign word_dat = {hi_q, lo_q};
  assign csum     = csum_q;

endmodule

// File: rtl/boot_loader.sv
// Loads a framed byte stream into CPU memory while holding the CPU in reset, then releases it.
// Last data byte to write strobe: 1 cycle; Rx_Ready low outside receive states and in S_Write.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int DataWidth = WORD_W,
  parameter int AddrWidth = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [7:0]           Rx_Data,
  input  logic                 Rx_Valid,
  output logic                 Rx_Ready,
  output logic [AddrWidth-1:0] Mem_Addr,
  output logic [DataWidth-1:0] Mem_Data,
  output logic                 Mem_Wr,
  output logic                 Cpu_Reset,
  input  logic                 Cpu_Halt,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Error
);

  localparam logic [LEN_W-1:0]     MaxWords = LEN_W'(2 ** AddrWidth);
  localparam logic [AddrWidth:0]   CntOne   = {{AddrWidth{1'b0}}, 1'b1};
  localparam logic [AddrWidth-1:0] AddrOne  = {{(AddrWidth-1){1'b0}}, 1'b1};

  state_t state_q, state_n;

  logic [AddrWidth-1:0] addr_q;
  logic [AddrWidth:0]   cnt_q;
  logic [AddrWidth:0]   n_q;
  logic                 cpu_rst_q;

  logic                 xfer;
  logic                 hi_en, lo_en, csum_clr, csum_en;
  logic [BYTE_W-1:0]    asm_hi;
  logic [WORD_W-1:0]    asm_word;
  logic [CSUM_W-1:0]    asm_csum;
  logic [LEN_W-1:0]     len_word;
  logic [AddrWidth:0]   cnt_next;
  logic                 last_word;

  assign xfer      = Rx_Valid & Rx_Ready;
  assign len_word  = {asm_hi, Rx_Data};
  assign cnt_next  = cnt_q + CntOne;
  assign last_word = (cnt_next == n_q);

  loader_word_assembler u_asm (
    .Clk      (Clk),
    .Reset    (Reset),
    .byte_dat (Rx_Data),
    .hi_en    (hi_en),
    .lo_en    (lo_en),
    .csum_clr (csum_clr),
    .csum_en  (csum_en),
    .hi_dat   (asm_hi),
    .word_dat (asm_word),
    .csum     (asm_csum)
  );

  always_comb begin
    state_n  = state_q;
    Rx_Ready = 1'b0;
    hi_en    = 1'b0;
    lo_en    = 1'b0;
    csum_clr = 1'b0;
    csum_en  = 1'b0;
    case (state_q)
      S_Idle, S_Halted, S_Error: begin
        if (Start) begin
          state_n  = S_LenHi;
          csum_clr = 1'b1;
        end
      end
      S_LenHi: begin
        Rx_Ready = 1'b1;
        if (xfer) begin
          hi_en   = 1'b1;
          state_n = S_LenLo;
        end
      end
      S_LenLo: begin
        Rx_Ready = 1'b1;
        if (xfer) begin
          if (len_word > MaxWords)  state_n = S_Error;
          else if (len_word == '0)  state_n = S_Check;
          else                      state_n = S_DataHi;
        end
      end
      S_DataHi: begin
        Rx_Ready = 1'b1;
        if (xfer) begin
          hi_en   = 1'b1;
          csum_en = 1'b1;
          state_n = S_DataLo;
        end
      end
      S_DataLo: begin
        Rx_Ready = 1'b1;
        if (xfer) begin
          lo_en   = 1'b1;
          csum_en = 1'b1;
          state_n = S_Write;
        end
      end
      S_Write: state_n = last_word ? S_Check : S_DataHi;
      S_Check: begin
        Rx_Ready = 1'b1;
        if (xfer) state_n = (Rx_Data == asm_csum) ? S_Run : S_Error;
      end
      S_Run: begin
        if (!Cpu_Halt) state_n = S_Halted;
      end
      default: state_n = S_Idle;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_Idle;
      addr_q    <= '0;
      cnt_q     <= '0;
      n_q       <= '0;
      cpu_rst_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      // Registered so the CPU reset release cannot glitch on FSM decode.
      cpu_rst_q <= (state_n == S_Run) || (state_n == S_Halted);
      if (state_q == S_LenLo && xfer) begin
        n_q    <= len_word[AddrWidth:0];
        addr_q <= '0;
        cnt_q  <= '0;
      end else if (state_q == S_Write) begin
        cnt_q <= cnt_next;
        // Hold on the final word so a full image leaves the address at the top, not 0.
        if (!last_word) addr_q <= addr_q + AddrOne;
      end
    end
  end

  assign Mem_Addr  = addr_q;
  assign Mem_Data  = asm_word;
  assign Mem_Wr    = (state_q != S_Write);
  assign Cpu_Reset = cpu_rst_q;
  assign Busy      = (state_q == S_LenHi) || (state_q == S_LenLo) || (state_q == S_DataHi) ||
                     (state_q == S_DataLo) || (state_q == S_Write) || (state_q == S_Check);
  assign Done      = (state_q == S_Halted);
  assign Error     = (state_q == S_Error);

endmodule

// File: tb/tb_boot_loader.sv
// Directed-sequence bench with random image data and random Rx_Valid gaps, checked against
// a frame/memory model built from the byte-stream rules.
module tb_boot_loader;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [7:0]  Rx_Data;
  logic        Rx_Valid;
  logic        Rx_Ready;
  logic [7:0]  Mem_Addr;
  logic [15:0] Mem_Data;
  logic        Mem_Wr;
  logic        Cpu_Reset;
  logic        Cpu_Halt;
  logic        Busy;
  logic        Done;
  logic        Error;

  int errors = 0;
  int checks = 0;

  logic [15:0] tb_mem [0:255];
  logic [15:0] img [$];
  int          wr_cnt = 0;
  int          wr0_cnt = 0;
  logic [7:0]  last_wr_addr = '0;

  boot_loader dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Rx_Data   (Rx_Data),
    .Rx_Valid  (Rx_Valid),
    .Rx_Ready  (Rx_Ready),
    .Mem_Addr  (Mem_Addr),
    .Mem_Data  (Mem_Data),
    .Mem_Wr    (Mem_Wr),
    .Cpu_Reset (Cpu_Reset),
    .Cpu_Halt  (Cpu_Halt),
    .Busy      (Busy),
    .Done      (Done),
    .Error     (Error)
  );

  always #5 Clk = ~Clk;

  // Memory the CPU would fetch from: captures every active-low write strobe.
  always @(posedge Clk) begin
    if (Mem_Wr === 1'b0) begin
      tb_mem[Mem_Addr] <= Mem_Data;
      wr_cnt           <= wr_cnt + 1;
      last_wr_addr     <= Mem_Addr;
      if (Mem_Addr == 8'h00) wr0_cnt <= wr0_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int cyc;
    if (gaps) begin
      int idle;
      idle = $urandom_range(0, 3);
      for (int k = 0; k < idle; k++) begin
        Rx_Valid = 1'b0;
        Rx_Data  = 8'($urandom);
        tick();
      end
    end
    Rx_Data  = b;
    Rx_Valid = 1'b1;
    cyc = 0;
    while (!Rx_Ready && cyc < 200) begin
      tick();
      cyc++;
    end
    if (cyc >= 200) check("rx_ready_timeout", {31'b0, Rx_Ready}, 32'd1);
    tick();
    Rx_Valid = 1'b0;
  endtask

  // Frame: LEN_HI LEN_LO, then each word high byte first, then XOR of all data bytes.
  task automatic send_frame(input int n, input bit gaps, input bit bad_csum, input bit start_mid);
    logic [7:0] cs;
    logic [15:0] w;
    cs = 8'h00;
    send_byte(8'(n >> 8), gaps);
    send_byte(8'(n), gaps);
    for (int i = 0; i < n; i++) begin
      w = img[i];
      if (start_mid && i == n / 2) Start = 1'b1;
      send_byte(w[15:8], gaps);
      Start = 1'b0;
      send_byte(w[7:0], gaps);
      check("wr_strobe", {31'b0, Mem_Wr}, 32'd0);
      check("wr_addr", {24'b0, Mem_Addr}, i & 32'hFF);
      check("wr_data", {16'b0, Mem_Data}, {16'b0, w});
      cs = cs ^ w[15:8] ^ w[7:0];
    end
    send_byte(bad_csum ? (cs ^ 8'h01) : cs, gaps);
  endtask

  task automatic rand_img(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back(16'($urandom));
  endtask

  task automatic check_mem(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < img.size(); i++)
      if (tb_mem[i] !== img[i]) bad++;
    check(tag, bad, 0);
  endtask

  task automatic halt_cpu();
    Cpu_Halt = 1'b0;
    tick();
    Cpu_Halt = 1'b1;
    check("halt_done", {31'b0, Done}, 32'd1);
    check("halt_cpu_reset", {31'b0, Cpu_Reset}, 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_ready"}, {31'b0, Rx_Ready}, 32'd0);
    check({tag, "_mem_addr"}, {24'b0, Mem_Addr}, 32'd0);
    check({tag, "_mem_data"}, {16'b0, Mem_Data}, 32'd0);
    check({tag, "_mem_wr"}, {31'b0, Mem_Wr}, 32'd1);
    check({tag, "_cpu_reset"}, {31'b0, Cpu_Reset}, 32'd0);
    check({tag, "_busy"}, {31'b0, Busy}, 32'd0);
    check({tag, "_done"}, {31'b0, Done}, 32'd0);
    check({tag, "_error"}, {31'b0, Error}, 32'd0);
  endtask

  initial begin
    int w0;
    Reset    = 1'b0;
    Start    = 1'b0;
    Rx_Data  = 8'h00;
    Rx_Valid = 1'b0;
    Cpu_Halt = 1'b1;
    repeat (3) tick();
    check_reset_vals("rst");
    Reset = 1'b1;
    tick();

    // 1: two-word frame, checksum 0x40, then CPU halt
    pulse_start();
    check("t1_busy", {31'b0, Busy}, 32'd1);
    check("t1_rdy", {31'b0, Rx_Ready}, 32'd1);
    check("t1_cpu_held", {31'b0, Cpu_Reset}, 32'd0);
    img.delete();
    img.push_back(16'h1234);
    img.push_back(16'hABCD);
    w0 = wr_cnt;
    send_frame(2, 1'b0, 1'b0, 1'b0);
    check("t1_cpu_run", {31'b0, Cpu_Reset}, 32'd1);
    check("t1_busy_off", {31'b0, Busy}, 32'd0);
    check("t1_done_pre", {31'b0, Done}, 32'd0);
    check("t1_wr_cnt", wr_cnt - w0, 32'd2);
    check_mem("t1_mem");
    Cpu_Halt = 1'b0;  // ignored until S_Run... already there, so halts next edge
    tick();
    Cpu_Halt = 1'b1;
    check("t1_done", {31'b0, Done}, 32'd1);
    check("t1_cpu_stays", {31'b0, Cpu_Reset}, 32'd1);

    // 2: bad checksum, then recovery
    pulse_start();
    check("t2_cpu_reheld", {31'b0, Cpu_Reset}, 32'd0);
    check("t2_done_clr", {31'b0, Done}, 32'd0);
    send_frame(2, 1'b0, 1'b1, 1'b0);
    check("t2_error", {31'b0, Error}, 32'd1);
    check("t2_cpu_held", {31'b0, Cpu_Reset}, 32'd0);
    check("t2_done", {31'b0, Done}, 32'd0);
    check("t2_rdy", {31'b0, Rx_Ready}, 32'd0);
    repeat (3) tick();
    check("t2_error_sticky", {31'b0, Error}, 32'd1);
    pulse_start();
    check("t2_error_clr", {31'b0, Error}, 32'd0);
    rand_img(5);
    send_frame(5, 1'b1, 1'b0, 1'b0);
    check("t2_cpu_run", {31'b0, Cpu_Reset}, 32'd1);
    check_mem("t2_mem");
    halt_cpu();

    // 3: length 257 rejected right after LEN_LO
    pulse_start();
    w0 = wr_cnt;
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    check("t3_error", {31'b0, Error}, 32'd1);
    check("t3_busy", {31'b0, Busy}, 32'd0);
    Rx_Valid = 1'b1;
    repeat (5) tick();
    Rx_Valid = 1'b0;
    check("t3_no_wr", wr_cnt - w0, 32'd0);
    check("t3_cpu_held", {31'b0, Cpu_Reset}, 32'd0);

    // 4: empty image, then two-word frame with random valid gaps
    pulse_start();
    w0 = wr_cnt;
    img.delete();
    send_frame(0, 1'b1, 1'b0, 1'b0);
    check("t4_cpu_run", {31'b0, Cpu_Reset}, 32'd1);
    check("t4_no_wr", wr_cnt - w0, 32'd0);
    halt_cpu();
    pulse_start();
    w0 = wr_cnt;
    img.push_back(16'h1234);
    img.push_back(16'hABCD);
    send_frame(2, 1'b1, 1'b0, 1'b0);
    check("t4_cpu_run2", {31'b0, Cpu_Reset}, 32'd1);
    check("t4_wr_cnt", wr_cnt - w0, 32'd2);
    check_mem("t4_mem");
    halt_cpu();

    // 5: asynchronous reset mid-frame
    tb_mem[0] = 16'h0000;
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'hAB, 1'b0);
    check("t5_busy_pre", {31'b0, Busy}, 32'd1);
    #2;
    Reset = 1'b0;
    #1;
    check_reset_vals("t5_async");
    check("t5_mem0_kept", {16'b0, tb_mem[0]}, 32'h1234);
    tick();
    Reset = 1'b1;
    tick();
    // Start with a valid byte present in S_Idle: that byte must not be consumed.
    Rx_Data  = 8'h55;
    Rx_Valid = 1'b1;
    Start    = 1'b1;
    tick();
    Start    = 1'b0;
    Rx_Valid = 1'b0;
    check("t5_rdy", {31'b0, Rx_Ready}, 32'd1);
    rand_img(3);
    send_frame(3, 1'b1, 1'b0, 1'b0);
    check("t5_cpu_run", {31'b0, Cpu_Reset}, 32'd1);
    check("t5_error", {31'b0, Error}, 32'd0);
    check_mem("t5_mem");
    halt_cpu();

    // 6: full 256-word image, Start mid-load ignored
    pulse_start();
    rand_img(256);
    w0 = wr_cnt;
    begin
      int z0;
      z0 = wr0_cnt;
      send_frame(256, 1'b0, 1'b0, 1'b1);
      check("t6_wr0_once", wr0_cnt - z0, 32'd1);
    end
    check("t6_cpu_run", {31'b0, Cpu_Reset}, 32'd1);
    check("t6_wr_cnt", wr_cnt - w0, 32'd256);
    check("t6_last_addr", {24'b0, last_wr_addr}, 32'hFF);
    check("t6_addr_hold", {24'b0, Mem_Addr}, 32'hFF);
    check_mem("t6_mem");
    halt_cpu();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
